// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as START, DATA (LSB first), optional PARITY, STOP.
// Define UART_TX_CTRL_2STOP_EN to stretch STOP to two cycles.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  ser_data,
   output logic                  par_bit,
   output logic [1:0]            mux_sel,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_reg;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic                  par_en_reg;
   logic                  par_typ_reg;
   logic                  par_sum_reg;
   logic                  stop_last;
   logic                  accept;

`ifdef UART_TX_CTRL_2STOP_EN
   logic                  stop_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stop_cnt_reg <= 1'b0;
      end else if (state_reg == STOP) begin
         stop_cnt_reg <= ~stop_cnt_reg;
      end else begin
         stop_cnt_reg <= 1'b0;
      end
   end

   assign stop_last = stop_cnt_reg;
`else
   assign stop_last = 1'b1;
`endif

   // A new frame can only be taken from IDLE or the final STOP cycle.
   assign accept = data_valid && ((state_reg == IDLE) || ((state_reg == STOP) && stop_last));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (data_valid) state_next = START;
         START:   state_next = DATA;
         DATA:    if (bit_cnt_reg == LAST_BIT) state_next = par_en_reg ? PARITY : STOP;
         PARITY:  state_next = STOP;
         STOP:    if (stop_last) state_next = data_valid ? START : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mux_sel = 2'b11;
      case (state_reg)
         START:   mux_sel = 2'b00;
         DATA:    mux_sel = 2'b01;
         PARITY:  mux_sel = 2'b10;
         default: mux_sel = 2'b11;
      endcase
   end

   assign busy     = (state_reg != IDLE);
   assign ser_data = (state_reg == DATA) && shift_reg[0];
   // Parity sum and type are both latched at accept, so the result holds until the next accept.
   assign par_bit  = par_sum_reg ^ par_typ_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         par_en_reg  <= 1'b0;
         par_typ_reg <= 1'b0;
         par_sum_reg <= 1'b0;
      end else begin
         if (accept) begin
            shift_reg   <= p_data;
            par_en_reg  <= par_en;
            par_typ_reg <= par_typ;
            par_sum_reg <= ^p_data;
         end
         if (state_reg == START) begin
            bit_cnt_reg <= '0;
         end else if (state_reg == DATA) begin
            shift_reg   <= shift_reg >> 1;
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed table, back-to-back, reset abort and randomized frames
// compared cycle by cycle against a frame-sequence model.
module tb_uart_tx_ctrl;

   localparam int DW = 8;
`ifdef UART_TX_CTRL_2STOP_EN
   localparam int STOP_BITS = 2;
`else
   localparam int STOP_BITS = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] p_data = '0;
   logic          data_valid = 1'b0;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic          ser_data;
   logic          par_bit;
   logic [1:0]    mux_sel;
   logic          busy;

   int tests = 0;
   int fails = 0;

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .ser_data   (ser_data),
      .par_bit    (par_bit),
      .mux_sel    (mux_sel),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          pe;
      logic          pt;
      logic          exp_par;
      int            exp_len;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected frame: START, DATA bits LSB first, optional PARITY, STOP_BITS stops.
   // Caller has presented the request before the accepting edge.
   task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                            input bit hold_dv, input bit chain,
                            input logic [DW-1:0] nd, input logic npe, input logic npt,
                            output int bc);
      logic [1:0] es[$];
      logic       ed[$];
      logic       ep;
      int         guard;
      es.push_back(2'b00); ed.push_back(1'b0);
      for (int i = 0; i < DW; i++) begin
         es.push_back(2'b01); ed.push_back(d[i]);
      end
      if (pe) begin
         es.push_back(2'b10); ed.push_back(1'b0);
      end
      for (int s = 0; s < STOP_BITS; s++) begin
         es.push_back(2'b11); ed.push_back(1'b0);
      end
      ep = (($countones(d) & 1) == 1) ^ pt;
      bc = 0;
      for (int i = 0; i < es.size(); i++) begin
         @(negedge clk);
         chk("mux_sel", int'(mux_sel), int'(es[i]));
         chk("busy", int'(busy), 1);
         chk("par_bit", int'(par_bit), int'(ep));
         if (es[i] == 2'b01) chk("ser_data", int'(ser_data), int'(ed[i]));
         if (busy) bc++;
         if (i == es.size() - 1) begin
            data_valid = chain;
            p_data     = nd;
            par_en     = npe;
            par_typ    = npt;
         end else begin
            data_valid = hold_dv ? 1'b1 : 1'($urandom);
            p_data     = DW'($urandom);
            par_en     = 1'($urandom);
            par_typ    = 1'($urandom);
         end
      end
      if (!chain) begin
         @(negedge clk);
         guard = 0;
         while (busy && guard < 30) begin
            bc++;
            guard++;
            @(negedge clk);
         end
         chk("idle_mux_sel", int'(mux_sel), 3);
         chk("idle_busy", int'(busy), 0);
         chk("held_par_bit", int'(par_bit), int'(ep));
      end
      $display("[TB] frame d=%02h pe=%0d pt=%0d chain=%0d busy_cycles=%0d", d, pe, pt, chain, bc);
   endtask

   task automatic request(input logic [DW-1:0] d, input logic pe, input logic pt);
      data_valid = 1'b1;
      p_data     = d;
      par_en     = pe;
      par_typ    = pt;
   endtask

   initial begin
      int            bc;
      logic [DW-1:0] cd, nd;
      logic          cpe, cpt, npe, npt;
      bit            chain;

      tbl[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 10 + STOP_BITS};
      tbl[1] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, exp_par: 1'b0, exp_len: 10 + STOP_BITS};
      tbl[2] = '{d: 8'h80, pe: 1'b0, pt: 1'b0, exp_par: 1'b1, exp_len: 9 + STOP_BITS};
      tbl[3] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 10 + STOP_BITS};
      tbl[4] = '{d: 8'h00, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 10 + STOP_BITS};
      tbl[5] = '{d: 8'h01, pe: 1'b0, pt: 1'b1, exp_par: 1'b0, exp_len: 9 + STOP_BITS};

      // Reset state
      #2;
      chk("rst_mux_sel", int'(mux_sel), 3);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ser_data", int'(ser_data), 0);
      chk("rst_par_bit", int'(par_bit), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);

      // Directed table
      for (int v = 0; v < 6; v++) begin
         request(tbl[v].d, tbl[v].pe, tbl[v].pt);
         run_frame(tbl[v].d, tbl[v].pe, tbl[v].pt, 1'b0, 1'b0, '0, 1'b0, 1'b0, bc);
         chk("tbl_len", bc, tbl[v].exp_len);
         chk("tbl_par", int'(par_bit), int'(tbl[v].exp_par));
      end

      // Back-to-back with data_valid held high; with two stops this also
      // verifies the request is taken only on the second STOP cycle.
      request(8'h55, 1'b1, 1'b0);
      run_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, bc);
      run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, bc);

      // Reset during DATA bit 4
      request(8'hC3, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         data_valid = 1'b0;
      end
      chk("bit4_mux_sel", int'(mux_sel), 1);
      chk("bit4_ser_data", int'(ser_data), 0);
      rst = 1'b1;
      #1;
      chk("async_mux_sel", int'(mux_sel), 3);
      chk("async_busy", int'(busy), 0);
      chk("async_par_bit", int'(par_bit), 0);
      chk("async_ser_data", int'(ser_data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_abort_busy", int'(busy), 0);
      request(8'h96, 1'b1, 1'b0);
      run_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, bc);
      chk("after_abort_len", bc, 10 + STOP_BITS);

      // Randomized frames, sometimes chained
      cd  = DW'($urandom);
      cpe = 1'($urandom);
      cpt = 1'($urandom);
      request(cd, cpe, cpt);
      for (int k = 0; k < 40; k++) begin
         nd    = DW'($urandom);
         npe   = 1'($urandom);
         npt   = 1'($urandom);
         chain = (k < 39) && ($urandom_range(1, 0) == 1);
         run_frame(cd, cpe, cpt, 1'($urandom), chain, nd, npe, npt, bc);
         if (!chain) chk("rand_len", bc, 1 + DW + int'(cpe) + STOP_BITS);
         if (!chain && k < 39) request(nd, npe, npt);
         cd  = nd;
         cpe = npe;
         cpt = npt;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
